// File: rtl/clken_pkg.sv
// clken_pkg: shared constants, types and rate helper for clken_gen (CLKEN_SYNC_EN adds sync_i alignment)
package clken_pkg;
  localparam int ACC_W_DEF = 24;
  localparam int LOCK_CYCLES_DEF = 16;
  localparam int LOCK_W = $clog2(LOCK_CYCLES_DEF + 1);
  typedef logic [ACC_W_DEF-1:0] acc_t;
  function automatic int lock_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction
  function automatic acc_t step_for(input longint f_out, input longint f_clk);
    return acc_t'((f_out << ACC_W_DEF) / f_clk);
  endfunction
endpackage

// File: rtl/clken_if.sv
// clken_if: rate configuration in, strobes/phases/lock out for clken_gen
interface clken_if #(
  parameter int CHANNELS = 4,
  parameter int ACC_W = 24
);
  logic [CHANNELS*ACC_W-1:0] step_i;
  logic [CHANNELS-1:0] enable_i;
  logic sync_i;
  logic [CHANNELS-1:0] ce_o;
  logic [CHANNELS-1:0] phase_o;
  logic locked_o;
  modport master(output step_i, enable_i, sync_i, input ce_o, phase_o, locked_o);
  modport slave(input step_i, enable_i, sync_i, output ce_o, phase_o, locked_o);
endinterface

// File: rtl/clken_acc.sv
// clken_acc: one phase-accumulator channel producing a carry strobe and MSB phase
module clken_acc
  import clken_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             adv,
  input  logic             clr,
  input  logic [ACC_W-1:0] step,
  output logic             ce,
  output logic             phase
);
  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic carry, ce_q, ce_d, phase_q, phase_d;
  // next state: alignment clear wins over accumulation, idle channels hold
  always_comb begin
    {carry, sum} = {1'b0, acc_q} + {1'b0, step};
    acc_d = clr ? '0 : adv ? sum : acc_q;
    ce_d = adv & ~clr & carry;
    phase_d = clr ? 1'b0 : adv ? sum[ACC_W-1] : phase_q;
  end
  // state registers
  always_ff @(posedge clock) begin
    if (rst) begin
      acc_q <= '0;
      ce_q <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ce_q <= ce_d;
      phase_q <= phase_d;
    end
  end
  assign ce = ce_q;
  assign phase = phase_q;
endmodule

// File: rtl/clken_gen.sv
// clken_gen: multi-channel fractional clock-enable generator; define CLKEN_SYNC_EN for sync_i alignment
module clken_gen
  import clken_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input logic clock,
  input logic rst,
  clken_if.slave bus
);
  localparam int CW = lock_w(LOCK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(LOCK_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic locked_q, locked_d, clr;
  logic [CHANNELS-1:0] ce, ph;
  // settle counter saturates at its last value; lock latches one edge after it gets there
  always_comb begin
    cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
    locked_d = locked_q | (cnt_q == LAST);
  end
  // lock state registers
  always_ff @(posedge clock) begin
    if (rst) begin
      cnt_q <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      locked_q <= locked_d;
    end
  end
`ifdef CLKEN_SYNC_EN
  assign clr = bus.sync_i & locked_q;
`else
  logic unused_sync;
  assign unused_sync = bus.sync_i;
  assign clr = 1'b0;
`endif
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    clken_acc #(.ACC_W(ACC_W)) u_acc (
      .clock(clock),
      .rst(rst),
      .adv(locked_q & bus.enable_i[k]),
      .clr(clr),
      .step(bus.step_i[k*ACC_W +: ACC_W]),
      .ce(ce[k]),
      .phase(ph[k])
    );
  end
  assign bus.ce_o = ce;
  assign bus.phase_o = ph;
  assign bus.locked_o = locked_q;
endmodule

// File: tb/tb_clken_gen.sv
// tb_clken_gen: randomized scoreboard bench for clken_gen against an arithmetic rate model
module tb_clken_gen;
  import clken_pkg::*;
  localparam int N = 4;
  localparam int W = 24;
  localparam int LC = 16;
  localparam longint MOD = 64'd1 << W;
`ifdef CLKEN_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif
  typedef struct packed {
    logic lock;
    logic [N-1:0] ph;
    logic [N-1:0] ce;
  } exp_t;

  logic clock = 1'b0;
  logic rst = 1'b1;
  always #5 clock = ~clock;

  clken_if #(.CHANNELS(N), .ACC_W(W)) bus ();
  clken_gen #(.CHANNELS(N), .ACC_W(W), .LOCK_CYCLES(LC)) dut (
    .clock(clock),
    .rst(rst),
    .bus(bus.slave)
  );

  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;
  int ce_cnt[N];
  longint macc[N];
  logic [N-1:0] mce = '0;
  logic [N-1:0] mph = '0;
  logic mlock = 1'b0;
  int since = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_step(input int k, input logic [W-1:0] s);
    bus.step_i[k*W +: W] = s;
  endtask

  // reference: rate = step/2^W, carry out of a modulo-2^W sum is the strobe
  task automatic tick();
    longint t;
    if (rst) begin
      for (int k = 0; k < N; k++) macc[k] = 0;
      mce = '0;
      mph = '0;
      mlock = 1'b0;
      since = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (mlock && SYNC && bus.sync_i) begin
          macc[k] = 0;
          mce[k] = 1'b0;
          mph[k] = 1'b0;
        end else if (mlock && bus.enable_i[k]) begin
          t = macc[k] + longint'(bus.step_i[k*W +: W]);
          mce[k] = (t >= MOD);
          macc[k] = t % MOD;
          mph[k] = (macc[k] >= MOD / 2);
        end else begin
          mce[k] = 1'b0;
        end
      end
      if (since < LC) since++;
      if (since >= LC) mlock = 1'b1;
    end
    q.push_back(exp_t'{lock: mlock, ph: mph, ce: mce});
    @(negedge clock);
  endtask

  exp_t e_m, got_m;
  always @(posedge clock) begin
    #1;
    if (q.size() != 0) begin
      e_m = q.pop_front();
      got_m = {bus.locked_o, bus.phase_o, bus.ce_o};
      n_tests++;
      if (got_m !== e_m) begin
        n_fail++;
        $display("FAIL outputs at %0t: got lock=%b ph=%b ce=%b expected lock=%b ph=%b ce=%b",
                 $time, got_m.lock, got_m.ph, got_m.ce, e_m.lock, e_m.ph, e_m.ce);
      end
      for (int k = 0; k < N; k++) ce_cnt[k] += int'(bus.ce_o[k]);
    end
  end

  task automatic zero_counts();
    for (int k = 0; k < N; k++) ce_cnt[k] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
  endtask

  task automatic wait_lock(input string name);
    int n;
    n = 0;
    rst = 1'b0;
    while (!bus.locked_o && n < 100) begin
      tick();
      n++;
    end
    check(name, n, LC);
  endtask

  function automatic logic [W-1:0] pick_step();
    case ($urandom_range(0, 3))
      0: return '0;
      1: return '1;
      2: return W'($urandom);
      default: return W'(1) << $urandom_range(18, 23);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.step_i = '0;
    bus.enable_i = '1;
    bus.sync_i = 1'b0;
    set_step(0, 24'h200000);
    set_step(1, 24'h400000);
    set_step(2, 24'h000000);
    set_step(3, 24'hFFFFFF);
    do_reset();
    wait_lock("lock_after_reset");
    zero_counts();
    repeat (800) tick();
    check("ch0_800", ce_cnt[0], 100);
    check("ch1_800", ce_cnt[1], 200);
    repeat (200) tick();
    check("ch0_1000", ce_cnt[0], 125);
    check("ch1_1000", ce_cnt[1], 250);
    check("step0_1000", ce_cnt[2], 0);
    check("stepmax_1000", ce_cnt[3], 999);
    set_step(2, 24'h555555);
    repeat (20) tick();
    bus.enable_i[2] = 1'b0;
    zero_counts();
    repeat (7) tick();
    check("gap_no_ce2", ce_cnt[2], 0);
    bus.enable_i[2] = 1'b1;
    repeat (30) tick();
    begin
      int n;
      n = 0;
      while (macc[0] != 64'hC00000 && n < 20) begin
        tick();
        n++;
      end
      check("reach_c00000", macc[0], 64'hC00000);
    end
    rst = 1'b1;
    tick();
    check("midreset_ce", bus.ce_o, 0);
    check("midreset_phase", bus.phase_o, 0);
    check("midreset_locked", bus.locked_o, 0);
    wait_lock("lock_after_midreset");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) set_step($urandom_range(0, N - 1), pick_step());
      for (int k = 0; k < N; k++) bus.enable_i[k] = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
      bus.sync_i = ($urandom_range(0, 29) == 0);
      tick();
    end
    rst = 1'b0;
    bus.sync_i = 1'b0;
    bus.enable_i = '1;
`ifdef CLKEN_SYNC_EN
    set_step(0, 24'h200000);
    set_step(1, 24'h200000);
    do_reset();
    wait_lock("lock_before_sync");
    bus.enable_i[1] = 1'b0;
    repeat (3) tick();
    bus.enable_i[1] = 1'b1;
    repeat (5) tick();
    bus.sync_i = 1'b1;
    tick();
    bus.sync_i = 1'b0;
    zero_counts();
    repeat (7) tick();
    check("sync_no_early", ce_cnt[0] + ce_cnt[1], 0);
    tick();
    check("sync_together", bus.ce_o[1:0], 3);
    repeat (16) tick();
    check("sync_ch0_count", ce_cnt[0], 3);
    check("sync_ch1_count", ce_cnt[1], 3);
`endif
    repeat (10) tick();
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
